// File: rtl/memory_access_stage.sv
// Memory access stage: turns execute results into D-cache load/store transactions
// and delivers a registered, one-cycle writeback pulse.
module memory_access_stage #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [1:0]      ex_mem_size,
    input  logic            ex_mem_unsigned,
    input  logic [RD_W-1:0] ex_rd,
    input  logic            ex_reg_write,
    input  logic            flush,
    output logic            mem_ready,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wstrb,
    input  logic            dmem_resp_valid,
    input  logic [XLEN-1:0] dmem_resp_rdata,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_reg_write,
    output logic            mem_misaligned
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]      state_q,   state_d;
    logic [XLEN-1:0] addr_q,    addr_d;
    logic            we_q,      we_d;
    logic [XLEN-1:0] wdata_q,   wdata_d;
    logic [7:0]      wstrb_q,   wstrb_d;
    logic [1:0]      size_q,    size_d;
    logic            uns_q,     uns_d;
    logic [RD_W-1:0] rd_q,      rd_d;
    logic            rw_q,      rw_d;
    logic            drop_q,    drop_d;
    logic            wb_valid_q, wb_valid_d;
    logic [XLEN-1:0] wb_data_q,  wb_data_d;
    logic [RD_W-1:0] wb_rd_q,    wb_rd_d;
    logic            wb_rw_q,    wb_rw_d;
    logic            mis_q,      mis_d;

    logic [2:0]      ex_off_c;
    logic [2:0]      align_mask_c;
    logic [7:0]      byte_mask_c;
    logic            misaligned_c;
    logic [XLEN-1:0] lane_c;
    logic [XLEN-1:0] load_ext_c;

    // Alignment and byte-lane mask for the incoming op
    always_comb begin
        ex_off_c = ex_alu_result[2:0];
        case (ex_mem_size)
            2'd0:    begin align_mask_c = 3'b000; byte_mask_c = 8'h01; end
            2'd1:    begin align_mask_c = 3'b001; byte_mask_c = 8'h03; end
            2'd2:    begin align_mask_c = 3'b011; byte_mask_c = 8'h0F; end
            default: begin align_mask_c = 3'b111; byte_mask_c = 8'hFF; end
        endcase
        misaligned_c = |(ex_off_c & align_mask_c);
    end

    // Load lane extraction and sign/zero extension from the latched op
    always_comb begin
        lane_c = dmem_resp_rdata >> {addr_q[2:0], 3'b000};
        case (size_q)
            2'd0: load_ext_c = uns_q ? {{(XLEN-8){1'b0}}, lane_c[7:0]}
                                     : {{(XLEN-8){lane_c[7]}}, lane_c[7:0]};
            2'd1: load_ext_c = uns_q ? {{(XLEN-16){1'b0}}, lane_c[15:0]}
                                     : {{(XLEN-16){lane_c[15]}}, lane_c[15:0]};
            2'd2: load_ext_c = uns_q ? {{(XLEN-32){1'b0}}, lane_c[31:0]}
                                     : {{(XLEN-32){lane_c[31]}}, lane_c[31:0]};
            default: load_ext_c = lane_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            drop_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_rw_q    <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            rd_q       <= rd_d;
            rw_q       <= rw_d;
            drop_q     <= drop_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_rw_q    <= wb_rw_d;
            mis_q      <= mis_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        size_d     = size_q;
        uns_d      = uns_q;
        rd_d       = rd_q;
        rw_d       = rw_q;
        drop_d     = drop_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_rw_d    = wb_rw_q;
        mis_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ex_valid && !flush) begin
                    if (!ex_mem_read && !ex_mem_write) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ex_alu_result;
                        wb_rd_d    = ex_rd;
                        wb_rw_d    = ex_reg_write;
                    end else if (misaligned_c) begin
                        wb_valid_d = 1'b1;
                        mis_d      = 1'b1;
                        wb_data_d  = ex_alu_result;
                        wb_rd_d    = ex_rd;
                        wb_rw_d    = 1'b0;
                    end else begin
                        state_d = ST_REQ;
                        addr_d  = ex_alu_result;
                        we_d    = ex_mem_write;
                        wdata_d = ex_store_data << {ex_off_c, 3'b000};
                        wstrb_d = byte_mask_c << ex_off_c;
                        size_d  = ex_mem_size;
                        uns_d   = ex_mem_unsigned;
                        rd_d    = ex_rd;
                        rw_d    = ex_reg_write;
                        drop_d  = 1'b0;
                    end
                end
            end
            ST_REQ: begin
                // An accepted request always owes a response, even when flushed
                if (dmem_req_ready) begin
                    state_d = ST_WAIT;
                    drop_d  = flush;
                end else if (flush) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (dmem_resp_valid) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                    if (!drop_q && !flush) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        if (we_q) begin
                            wb_data_d = '0;
                            wb_rw_d   = 1'b0;
                        end else begin
                            wb_data_d = load_ext_c;
                            wb_rw_d   = rw_q;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_ready      = (state_q == ST_IDLE);
    assign dmem_req_valid = (state_q == ST_REQ);
    assign dmem_addr      = {addr_q[XLEN-1:3], 3'b000};
    assign dmem_we        = we_q;
    assign dmem_wdata     = wdata_q;
    assign dmem_wstrb     = wstrb_q;
    assign wb_valid       = wb_valid_q;
    assign wb_data        = wb_data_q;
    assign wb_rd          = wb_rd_q;
    assign wb_reg_write   = wb_rw_q;
    assign mem_misaligned = mis_q;

endmodule
